// File: rtl/evt_tgl_sync_arb.sv
// -----------------------------------------------------------------------------
// evt_tgl_sync_arb
//   Destination-side receiver for toggle-encoded event crossings. Each channel's
//   toggle is synchronised and edge-detected. Each detected edge is counted as
//   one pending event. Pending events drain one at a time through a
//   valid/ready slot, tagged with the channel ID. Channels are granted
//   round-robin.
//
// Parameters
//   NUM_CH       number of event channels (>=1)
//   SYNC_STAGES  synchroniser flops per channel (>=2)
//   CNT_W        pending counter width; saturates at 2^CNT_W-1
//
// Ports
//   clk_i        destination clock (only clock)
//   rstn_i       asynchronous active-low reset
//   evt_tgl_i    per-channel asynchronous toggle events
//   ack_tgl_o    per-channel registered toggle level, returned to the source
//   evt_valid_o  output slot holds an event
//   evt_ready_i  consumer accepts the presented event
//   evt_ch_o     channel ID of the presented event
//   pending_o    per-channel counter non-zero (slot event not included)
//
// Optional feature (macro EVT_TGL_SYNC_OVF_EN)
//   ovf_o        sticky per-channel flag; set when an increment is dropped
//   ovf_clr_i    per-channel clear of ovf_o; a same-cycle set wins
// -----------------------------------------------------------------------------
module evt_tgl_sync_arb #(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned CNT_W       = 4,
  localparam int unsigned ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NUM_CH-1:0] evt_tgl_i,
  output logic [NUM_CH-1:0] ack_tgl_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [ID_W-1:0]   evt_ch_o,
  output logic [NUM_CH-1:0] pending_o
`ifdef EVT_TGL_SYNC_OVF_EN
  ,
  input  logic [NUM_CH-1:0] ovf_clr_i,
  output logic [NUM_CH-1:0] ovf_o
`endif
);

  localparam int unsigned      WU_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [WU_W-1:0]  WU_INIT = WU_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ID_W-1:0]  PTR_RST = ID_W'(NUM_CH - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                  sync_s;
  logic [NUM_CH-1:0]                  hist_q;
  logic [NUM_CH-1:0]                  ev;
  logic [WU_W-1:0]                    wu_q, wu_d;

  logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]                  nz;
  logic [NUM_CH-1:0]                  pop;
  logic [NUM_CH-1:0]                  pend_q;

  slot_state_e                        state_q, state_d;
  logic [ID_W-1:0]                    ch_q, ch_d;
  logic [ID_W-1:0]                    ptr_q, ptr_d;
  logic [ID_W-1:0]                    grant;
  logic                               any_nz;
  logic                               can_load;

  // Synchroniser chain, edge history and warm-up counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      hist_q <= '0;
      wu_q   <= WU_INIT;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], evt_tgl_i};
      hist_q <= sync_s;
      wu_q   <= wu_d;
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Warm-up hides the reset-to-level transitions while the chain fills, so a
  // source already at toggle level 1 does not produce a spurious event.
  always_comb begin
    wu_d = wu_q;
    if (wu_q != '0) begin
      wu_d = wu_q - WU_W'(1);
    end
  end

  assign ev = (wu_q == '0) ? (sync_s ^ hist_q) : '0;

  // Per-channel non-zero flags from the registered counters.
  always_comb begin
    nz = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      nz[c] = (cnt_q[c] != '0);
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int unsigned idx;
    grant  = '0;
    any_nz = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(ptr_q) + 32'd1 + i) % NUM_CH;
      if (!any_nz && nz[ID_W'(idx)]) begin
        any_nz = 1'b1;
        grant  = ID_W'(idx);
      end
    end
  end

  // Output slot next state: load on grant, empty only on accept with nothing pending.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    ptr_d    = ptr_q;
    pop      = '0;
    can_load = (state_q == S_EMPTY) || evt_ready_i;
    if (can_load) begin
      if (any_nz) begin
        state_d    = S_FULL;
        ch_d       = grant;
        ptr_d      = grant;
        pop[grant] = 1'b1;
      end else begin
        state_d = S_EMPTY;
      end
    end
  end

  // Pending counters; a simultaneous inc and pop cancel, even at saturation.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      case ({ev[c], pop[c]})
        2'b10: begin
          if (cnt_q[c] != CNT_MAX) begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
        2'b01:   cnt_d[c] = cnt_q[c] - CNT_W'(1);
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  // Slot, arbitration pointer and counter state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_EMPTY;
      ch_q    <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pend_q  <= nz;
    end
  end

  assign ack_tgl_o   = hist_q;
  assign evt_valid_o = (state_q == S_FULL);
  assign evt_ch_o    = ch_q;
  assign pending_o   = pend_q;

`ifdef EVT_TGL_SYNC_OVF_EN
  logic [NUM_CH-1:0] ovf_set;
  logic [NUM_CH-1:0] ovf_q;

  // An increment is dropped only when the counter is full and not popping.
  always_comb begin
    ovf_set = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ovf_set[c] = ev[c] && !pop[c] && (cnt_q[c] == CNT_MAX);
    end
  end

  // Sticky overflow flags; set has priority over clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr_i) | ovf_set;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_evt_tgl_sync_arb.sv
// -----------------------------------------------------------------------------
// tb_evt_tgl_sync_arb
//   Scoreboard bench for evt_tgl_sync_arb (NUM_CH=4, SYNC_STAGES=2, CNT_W=2).
//   A reference model tracks per-channel event counts, arrival delays and the
//   round-robin pointer as integers. It pushes each predicted slot load into
//   an expected queue. A separate monitor pops that queue on every accept.
// -----------------------------------------------------------------------------
module tb_evt_tgl_sync_arb;

  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 2;
  localparam int unsigned ID_W        = 2;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NUM_CH-1:0] evt_tgl;
  logic [NUM_CH-1:0] ack;
  logic              valid;
  logic              ready;
  logic [ID_W-1:0]   ch;
  logic [NUM_CH-1:0] pend;
`ifdef EVT_TGL_SYNC_OVF_EN
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] ovf_clr;
`endif

  evt_tgl_sync_arb #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .evt_tgl_i   (evt_tgl),
    .ack_tgl_o   (ack),
    .evt_valid_o (valid),
    .evt_ready_i (ready),
    .evt_ch_o    (ch),
    .pending_o   (pend)
`ifdef EVT_TGL_SYNC_OVF_EN
    ,
    .ovf_clr_i   (ovf_clr),
    .ovf_o       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int chn;
  } arr_t;

  int                m_cnt [NUM_CH];
  bit                m_full;
  int                m_ptr;
  bit [NUM_CH-1:0]   m_prev;
  bit [NUM_CH-1:0]   m_pend;
  bit [NUM_CH-1:0]   m_ovf;
  int                cyc;
  arr_t              m_arr [$];
  int                exp_q [$];
  int                acc_q [$];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
    m_full = 1'b0;
    m_ptr  = NUM_CH - 1;
    m_pend = '0;
    m_ovf  = '0;
    m_prev = evt_tgl;
    cyc    = 0;
    m_arr.delete();
    exp_q.delete();
  endtask

  // Advance the model across the next rising edge using the inputs now applied.
  task automatic model_step();
    int g;
    bit can_load;
    bit [NUM_CH-1:0] set;
    arr_t a;
    g        = -1;
    set      = '0;
    can_load = !m_full || ready;
    for (int c = 0; c < NUM_CH; c++) m_pend[c] = (m_cnt[c] > 0);
    if (can_load) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        if (g < 0 && m_cnt[(m_ptr + i) % NUM_CH] > 0) g = (m_ptr + i) % NUM_CH;
      end
      if (g >= 0) begin
        m_full = 1'b1;
        m_ptr  = g;
        m_cnt[g]--;
        exp_q.push_back(g);
      end else begin
        m_full = 1'b0;
      end
    end
    cyc++;
    while (m_arr.size() > 0 && m_arr[0].due == cyc) begin
      a = m_arr.pop_front();
      if (m_cnt[a.chn] < CNT_MAX) m_cnt[a.chn]++;
      else set[a.chn] = 1'b1;
    end
`ifdef EVT_TGL_SYNC_OVF_EN
    m_ovf = (m_ovf & ~ovf_clr) | set;
`else
    m_ovf = m_ovf | set;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (evt_tgl[c] != m_prev[c]) begin
        a.due = cyc + SYNC_STAGES;
        a.chn = c;
        m_arr.push_back(a);
      end
    end
    m_prev = evt_tgl;
  endtask

  // Per-cycle model comparison and update.
  always @(negedge clk) begin
    if (!rstn) model_reset();
    check("valid", 32'(valid), 32'(m_full));
    check("pending", 32'(pend), 32'(m_pend));
`ifdef EVT_TGL_SYNC_OVF_EN
    check("ovf", 32'(ovf), 32'(m_ovf));
`endif
    if (rstn) model_step();
  end

  // Scoreboard monitor: every accepted event must match the next prediction.
  always @(negedge clk) begin
    if (rstn === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      acc_q.push_back(int'(ch));
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got ch %0d, expected no event (t=%0t)", ch, $time);
      end else begin
        check("sb_ch", 32'(ch), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(SYNC_STAGES + 3);
  endtask

  initial begin
    int lat;
    rstn    = 1'b0;
    evt_tgl = 4'b0101;
    ready   = 1'b1;
`ifdef EVT_TGL_SYNC_OVF_EN
    ovf_clr = '0;
`endif
    // Reset release with levels already high: ack follows after SYNC_STAGES+1.
    tick(3);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ch", 32'(ch), 32'd0);
    rstn = 1'b1;
    tick(SYNC_STAGES);
    check("ack_early", 32'(ack), 32'd0);
    tick(1);
    check("ack_level", 32'(ack), 32'b0101);
    tick(5);
    check("no_spurious", 32'(acc_q.size()), 32'd0);

    // Single toggle on ch2: one-cycle valid, SYNC_STAGES+2 after the edge.
    evt_tgl[2] = ~evt_tgl[2];
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (valid && lat == 0) lat = k;
      if (lat != 0) break;
    end
    check("t2_latency", 32'(lat), 32'(SYNC_STAGES + 2));
    check("t2_ch", 32'(ch), 32'd2);
    tick(1);
    check("t2_pulse", 32'(valid), 32'd0);
    tick(2);
    check("t2_ack", 32'(ack), 32'(evt_tgl));

    // Simultaneous toggles after reset, then a full round.
    do_reset();
    acc_q.delete();
    evt_tgl = evt_tgl ^ 4'b1011;
    tick(8);
    check("t3_n", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      check("t3_a", 32'(acc_q[0]), 32'd0);
      check("t3_b", 32'(acc_q[1]), 32'd1);
      check("t3_c", 32'(acc_q[2]), 32'd3);
    end
    acc_q.delete();
    evt_tgl = ~evt_tgl;
    tick(9);
    check("t3_n2", 32'(acc_q.size()), 32'd4);
    if (acc_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t3_rr", 32'(acc_q[i]), 32'(i));
    end

    // Back-pressure: ch1 three times, slot held stable.
    ready = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 3; i++) begin
      evt_tgl[1] = ~evt_tgl[1];
      tick(1);
    end
    tick(8);
    check("t4_valid", 32'(valid), 32'd1);
    check("t4_ch", 32'(ch), 32'd1);
    check("t4_pend1", 32'(pend[1]), 32'd1);
    ready = 1'b1;
    tick(8);
    check("t4_accepts", 32'(acc_q.size()), 32'd3);
    check("t4_empty", 32'(valid), 32'd0);
    check("t4_pend", 32'(pend), 32'd0);

    // Overflow: six events on ch0 with CNT_W=2, two are dropped.
    ready = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 6; i++) begin
      evt_tgl[0] = ~evt_tgl[0];
      tick(1);
    end
    tick(8);
    check("t5_valid", 32'(valid), 32'd1);
    check("t5_pend0", 32'(pend[0]), 32'd1);
`ifdef EVT_TGL_SYNC_OVF_EN
    check("t5_ovf_set", 32'(ovf[0]), 32'd1);
    tick(3);
    check("t5_ovf_sticky", 32'(ovf[0]), 32'd1);
    ovf_clr = 4'b0001;
    tick(1);
    ovf_clr = '0;
    tick(1);
    check("t5_ovf_clr", 32'(ovf[0]), 32'd0);
`endif
    ready = 1'b1;
    tick(10);
    check("t5_accepts", 32'(acc_q.size()), 32'd4);

    // Reset with slot full and counters loaded discards everything.
    ready = 1'b0;
    evt_tgl[2] = ~evt_tgl[2];
    tick(1);
    evt_tgl[3] = ~evt_tgl[3];
    tick(1);
    evt_tgl[2] = ~evt_tgl[2];
    tick(8);
    check("t6_full", 32'(valid), 32'd1);
    check("t6_pend_nz", 32'(pend != '0), 32'd1);
    rstn = 1'b0;
    tick(1);
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_pend", 32'(pend), 32'd0);
    check("t6_ack", 32'(ack), 32'd0);
    rstn = 1'b1;
    tick(SYNC_STAGES + 1);
    check("t6_ack_rel", 32'(ack), 32'(evt_tgl));
    ready = 1'b1;
    tick(6);
    check("t6_quiet", 32'(valid), 32'd0);

    // Randomised traffic and back-pressure.
    for (int n = 0; n < 1500; n++) begin
      ready = 1'($urandom_range(0, 1));
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 5) == 0) evt_tgl[c] = ~evt_tgl[c];
      end
`ifdef EVT_TGL_SYNC_OVF_EN
      ovf_clr = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
`endif
      tick(1);
    end
`ifdef EVT_TGL_SYNC_OVF_EN
    ovf_clr = '0;
`endif
    ready = 1'b1;
    tick(40);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(valid), 32'd0);
    check("drain_pend", 32'(pend), 32'd0);
    check("drain_ack", 32'(ack), 32'(evt_tgl));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
